// File: rtl/div_seq_handshake_if.sv
// Operand/result handshake bundle for div_seq_handshake.
// The producer/consumer side uses master; the divider uses slave.
interface div_seq_handshake_if #(
    parameter int unsigned DIVIDEND_WIDTH = 64,
    parameter int unsigned DIVISOR_WIDTH  = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      is_signed;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;
    logic                      overflow;

    modport master (
        output in_valid, is_signed, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, is_signed, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_seq_handshake.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed/unsigned per operation,
// C truncation semantics, valid/ready on operands and result.
module div_seq_handshake #(
    parameter int unsigned DIVIDEND_WIDTH = 64,
    parameter int unsigned DIVISOR_WIDTH  = 32
) (
    input  logic               clk,
    input  logic               reset,
    div_seq_handshake_if.slave bus
);
    localparam int unsigned DW = DIVIDEND_WIDTH;
    localparam int unsigned VW = DIVISOR_WIDTH;
    localparam int unsigned CW = (DW > 2) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_DBZ, SP_OVF} special_t;

    state_t          state;
    special_t        special;
    logic            dvd_neg;
    logic            quo_neg;
    logic [DW-1:0]   shreg;
    logic [VW-1:0]   dvs_mag;
    logic [VW:0]     prem;
    logic [CW-1:0]   cnt;

    logic [DW-1:0]   dvd_abs;
    logic [VW-1:0]   dvs_abs;
    logic [VW:0]     prem_sh;
    logic [VW:0]     trial;
    logic [VW-1:0]   rem_mag;
    logic            is_min_dvd;

    always_comb begin
        dvd_abs    = (bus.is_signed && bus.dividend[DW-1]) ? -bus.dividend : bus.dividend;
        dvs_abs    = (bus.is_signed && bus.divisor[VW-1])  ? -bus.divisor  : bus.divisor;
        is_min_dvd = (bus.dividend == {1'b1, {(DW-1){1'b0}}});
        prem_sh    = {prem[VW-1:0], shreg[DW-1]};
        trial      = prem_sh - {1'b0, dvs_mag};
        rem_mag    = prem[VW-1:0];
    end

    // shreg starts as |dividend| and fills with quotient bits from the LSB as the
    // dividend bits leave the MSB; on special cases it keeps the raw dividend instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            special         <= SP_NONE;
            dvd_neg         <= 1'b0;
            quo_neg         <= 1'b0;
            shreg           <= '0;
            dvs_mag         <= '0;
            prem            <= '0;
            cnt             <= '0;
            bus.in_ready    <= 1'b1;
            bus.out_valid   <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        dvd_neg      <= bus.is_signed & bus.dividend[DW-1];
                        quo_neg      <= bus.is_signed & (bus.dividend[DW-1] ^ bus.divisor[VW-1]);
                        dvs_mag      <= dvs_abs;
                        prem         <= '0;
                        cnt          <= CW'(DW - 1);
                        if (bus.divisor == '0) begin
                            special <= SP_DBZ;
                            shreg   <= bus.dividend;
                            state   <= FIXUP;
                        end else if (bus.is_signed && is_min_dvd && (bus.divisor == '1)) begin
                            special <= SP_OVF;
                            shreg   <= bus.dividend;
                            state   <= FIXUP;
                        end else begin
                            special <= SP_NONE;
                            shreg   <= dvd_abs;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[VW]) begin
                        prem  <= trial;
                        shreg <= {shreg[DW-2:0], 1'b1};
                    end else begin
                        prem  <= prem_sh;
                        shreg <= {shreg[DW-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= FIXUP;
                end
                FIXUP: begin
                    case (special)
                        SP_DBZ: begin
                            bus.quotient    <= '1;
                            bus.remainder   <= shreg[VW-1:0];
                            bus.div_by_zero <= 1'b1;
                            bus.overflow    <= 1'b0;
                        end
                        SP_OVF: begin
                            bus.quotient    <= shreg;
                            bus.remainder   <= '0;
                            bus.div_by_zero <= 1'b0;
                            bus.overflow    <= 1'b1;
                        end
                        default: begin
                            bus.quotient    <= quo_neg ? -shreg : shreg;
                            bus.remainder   <= dvd_neg ? -rem_mag : rem_mag;
                            bus.div_by_zero <= 1'b0;
                            bus.overflow    <= 1'b0;
                        end
                    endcase
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq_handshake.sv
// Directed and randomised checks of div_seq_handshake against an arithmetic reference
// model (64-bit dividend, 32-bit divisor build).
module tb_div_seq_handshake;
    localparam int unsigned DW = 64;
    localparam int unsigned VW = 32;
    localparam int BOUND = 300;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    div_seq_handshake_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus ();

    div_seq_handshake #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // C semantics: truncation toward zero, remainder follows the dividend's sign.
    task automatic model(input bit s, input logic [63:0] a, input logic [31:0] b,
                         output logic [63:0] q, output logic [31:0] r,
                         output bit dbz, output bit ovf);
        longint sa, sb, sq, sr;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 32'd0) begin
            q = '1; r = a[31:0]; dbz = 1'b1;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0; ovf = 1'b1;
        end else if (s) begin
            sa = a;
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq;
            r  = sr[31:0];
        end else begin
            q = a / {32'd0, b};
            r = 32'(a % {32'd0, b});
        end
    endtask

    task automatic send(input bit s, input logic [63:0] a, input logic [31:0] b, input bit keep);
        int n = 0;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        while (!bus.in_ready && n < BOUND) begin
            @(posedge clk); #1; n++;
        end
        if (n >= BOUND) check("accept_timeout", 64'(n), 64'(0));
        @(posedge clk); #1;
        if (!keep) begin
            bus.in_valid  = 1'b0;
            bus.dividend  = {$urandom, $urandom};
            bus.divisor   = $urandom;
            bus.is_signed = $urandom_range(0, 1);
        end
    endtask

    // Counts rising edges from the acceptance edge until out_valid is seen.
    task automatic wait_out(input string tag, input int exp_lat);
        int lat = 1;
        bit rdy = 1'b0;
        while (!bus.out_valid && lat < BOUND) begin
            if (bus.in_ready) rdy = 1'b1;
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_in_ready_low"}, 64'(rdy), 64'(0));
    endtask

    task automatic expect_out(input string tag, input logic [63:0] q, input logic [31:0] r,
                              input bit dbz, input bit ovf);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_q"}, bus.quotient, q);
        check({tag, "_r"}, 64'(bus.remainder), 64'(r));
        check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(dbz));
        check({tag, "_ovf"}, 64'(bus.overflow), 64'(ovf));
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_valid_fall"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic run_op(input string tag, input bit s, input logic [63:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] q,
                          input logic [31:0] r, input bit dbz, input bit ovf);
        send(s, a, b, 1'b0);
        wait_out(tag, lat);
        expect_out(tag, q, r, dbz, ovf);
        consume(tag);
    endtask

    initial begin
        logic [63:0] a, mq, inv;
        logic [31:0] b, mr;
        bit          s, mdbz, movf, seen;
        int          lat;

        bus.in_valid  = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_q", bus.quotient, 64'(0));
        check("rst_r", 64'(bus.remainder), 64'(0));
        check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
        check("rst_ovf", 64'(bus.overflow), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("u100_7", 1'b0, 64'd100, 32'd7, 66, 64'd14, 32'd2, 1'b0, 1'b0);
        run_op("s_m100_7", 1'b1, 64'(-100), 32'd7, 66, 64'(-14), 32'(-2), 1'b0, 1'b0);
        run_op("s_100_m7", 1'b1, 64'd100, 32'(-7), 66, 64'(-14), 32'd2, 1'b0, 1'b0);
        run_op("s_m100_m7", 1'b1, 64'(-100), 32'(-7), 66, 64'd14, 32'(-2), 1'b0, 1'b0);
        run_op("u_max_max", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 66,
               64'h0000_0001_0000_0001, 32'd0, 1'b0, 1'b0);
        run_op("s_min_min", 1'b1, 64'h8000_0000_0000_0000, 32'h8000_0000, 66,
               64'h0000_0001_0000_0000, 32'd0, 1'b0, 1'b0);
        run_op("u_dbz", 1'b0, 64'd12345, 32'd0, 2, '1, 32'd12345, 1'b1, 1'b0);
        run_op("s_dbz", 1'b1, 64'd12345, 32'd0, 2, '1, 32'd12345, 1'b1, 1'b0);
        run_op("s_ovf", 1'b1, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 2,
               64'h8000_0000_0000_0000, 32'd0, 1'b0, 1'b1);
        // 2^63 = 2^31 * (2^32 - 1) + 2^31
        run_op("u_min_m1", 1'b0, 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 66,
               64'h0000_0000_8000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // Backpressure: result must stay put for 10 cycles of out_ready low.
        send(1'b0, 64'd1000, 32'd33, 1'b0);
        wait_out("bp", 66);
        for (int i = 0; i < 10; i++) begin
            expect_out("bp_hold", 64'd30, 32'd10, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        consume("bp");

        // Operands presented during CALC/DONE are held off until the first IDLE edge.
        send(1'b0, 64'd500, 32'd9, 1'b1);
        bus.dividend = 64'd77;
        bus.divisor  = 32'd5;
        wait_out("ovl_a", 66);
        expect_out("ovl_a", 64'd55, 32'd5, 1'b0, 1'b0);
        consume("ovl_a");
        @(posedge clk); #1;
        check("ovl_b_accepted", 64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b0;
        wait_out("ovl_b", 66);
        expect_out("ovl_b", 64'd15, 32'd2, 1'b0, 1'b0);
        consume("ovl_b");

        // Asynchronous reset at CALC iteration 30 abandons the operation.
        send(1'b0, 64'd999_999, 32'd13, 1'b0);
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("mid_rst_q", bus.quotient, 64'(0));
        check("mid_rst_r", 64'(bus.remainder), 64'(0));
        #2;
        reset = 1'b0;
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("mid_rst_no_result", 64'(seen), 64'(0));
        run_op("post_rst", 1'b0, 64'd100, 32'd7, 66, 64'd14, 32'd2, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 64'h8000_0000_0000_0000;
                1:       a = 64'($urandom_range(0, 1000));
                2:       a = -64'($urandom_range(0, 1000));
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            model(s, a, b, mq, mr, mdbz, movf);
            lat = (mdbz || movf) ? 2 : 66;
            send(s, a, b, 1'b0);
            wait_out("rnd", lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            expect_out("rnd", mq, mr, mdbz, movf);
            if (!mdbz && !movf) begin
                inv = bus.quotient * (s ? {{32{b[31]}}, b} : {32'd0, b})
                    + (s ? {{32{bus.remainder[31]}}, bus.remainder} : {32'd0, bus.remainder});
                check("rnd_invariant", inv, a);
            end
            consume("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
